// File: rtl/store_buffer.sv
// In-order store buffer between the store alignment stage and the shared memory write port.
// Optional build macro STORE_BUF_COALESCE_EN merges a store into the youngest entry when it hits the same word.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 30
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          st_valid,
  output logic          st_ready,
  input  logic [31:0]   st_addr,
  input  logic [31:0]   st_data,
  input  logic [3:0]    st_mask,
  input  logic          st_dmem_we,
  input  logic          st_imem_we,
  output logic          mem_wvalid,
  input  logic          mem_wready,
  output logic [AW-1:0] mem_waddr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_wmask,
  output logic          mem_dmem_we,
  output logic          mem_imem_we,
  input  logic [31:0]   ld_addr,
  output logic          ld_hit,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef struct packed {
    logic [AW-1:0] waddr;
    logic [31:0]   data;
    logic [3:0]    mask;
    logic          dmem;
    logic          imem;
  } entry_t;

  entry_t        ent [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] count;

  logic          has_data;
  logic          full;
  logic          pop;
  logic          store_ok;
  logic          merge;
  logic          push;
  logic [AW-1:0] st_waddr;
  logic [AW-1:0] ld_waddr;
  entry_t        head;
  logic [PW-1:0] off;
  logic          unused_bits;

  assign unused_bits = ^{st_addr[1:0], ld_addr[1:0]};
  assign st_waddr    = st_addr[AW+1:2];
  assign ld_waddr    = ld_addr[AW+1:2];
  assign has_data    = (count != {CW{1'b0}});
  assign full        = (count == FULL_COUNT);
  assign pop         = has_data & mem_wready;
  // Zero-mask or target-less stores handshake normally but never occupy an entry.
  assign store_ok    = (st_mask != 4'b0000) & (st_dmem_we | st_imem_we);
  assign empty       = ~has_data;
  assign head        = ent[rptr];

`ifdef STORE_BUF_COALESCE_EN
  logic [PW-1:0] yptr;
  logic          coalesce_possible;
  entry_t        young;

  assign yptr  = wptr - PW'(1);
  assign young = ent[yptr];
  // A lone entry that is draining this cycle cannot absorb a merge.
  assign coalesce_possible = store_ok & has_data
                           & (young.waddr == st_waddr)
                           & (young.dmem == st_dmem_we) & (young.imem == st_imem_we)
                           & ~(pop & (count == CW'(1)));
  assign st_ready = ~full | coalesce_possible;
  assign merge    = st_valid & coalesce_possible;
`else
  assign st_ready = ~full;
  assign merge    = 1'b0;
`endif

  assign push = st_valid & st_ready & store_ok & ~merge;

  // Entry array, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= {PW{1'b0}};
      rptr  <= {PW{1'b0}};
      count <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        ent[i] <= '{waddr: {AW{1'b0}}, data: 32'h0000_0000, mask: 4'b0000,
                    dmem: 1'b0, imem: 1'b0};
      end
    end else begin
      if (push) begin
        ent[wptr] <= '{waddr: st_waddr, data: st_data, mask: st_mask,
                       dmem: st_dmem_we, imem: st_imem_we};
        wptr      <= wptr + PW'(1);
      end
`ifdef STORE_BUF_COALESCE_EN
      if (merge) begin
        for (int b = 0; b < 4; b++) begin
          if (st_mask[b]) begin
            ent[yptr].data[8*b +: 8] <= st_data[8*b +: 8];
          end
        end
        ent[yptr].mask <= young.mask | st_mask;
      end
`endif
      if (pop) begin
        rptr <= rptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Head entry presentation, forced to zero when nothing is pending.
  always_comb begin
    mem_wvalid  = 1'b0;
    mem_waddr   = {AW{1'b0}};
    mem_wdata   = 32'h0000_0000;
    mem_wmask   = 4'b0000;
    mem_dmem_we = 1'b0;
    mem_imem_we = 1'b0;
    if (has_data) begin
      mem_wvalid  = 1'b1;
      mem_waddr   = head.waddr;
      mem_wdata   = head.data;
      mem_wmask   = head.mask;
      mem_dmem_we = head.dmem;
      mem_imem_we = head.imem;
    end else begin
      mem_wvalid  = 1'b0;
    end
  end

  // Load hazard: any occupied dmem entry at the load's word address.
  always_comb begin
    ld_hit = 1'b0;
    off    = {PW{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - rptr;
      if (({1'b0, off} < count) && ent[i].dmem && (ent[i].waddr == ld_waddr)) begin
        ld_hit = 1'b1;
      end else begin
        ld_hit = ld_hit;
      end
    end
  end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Small in-order FIFO that sits directly downstream of the store alignment/mask stage.
- Captures each aligned store (word address, shifted data, byte mask, dmem/imem select) from the MEM stage.
- Drains entries to the shared memory write port whenever the port arbiter grants it; loads have priority on that port.
- Reports load-address hazards so the core can stall a load that would read stale memory.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2.
- AW, 30, width of the stored word address (address bits [31:2]).

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- st_valid  input  1  store request from the MEM stage.
- st_ready  output  1  buffer can accept the store this cycle.
- st_addr  input  32  byte address of the store; bits [1:0] are ignored.
- st_data  input  32  lane-aligned store data.
- st_mask  input  4  byte write-enable mask.
- st_dmem_we  input  1  store targets data memory.
- st_imem_we  input  1  store targets instruction memory.
- mem_wvalid  output  1  head entry presented on the memory write port.
- mem_wready  input  1  port grant; low while a load owns the port.
- mem_waddr  output  AW  word address of the head entry.
- mem_wdata  output  32  data of the head entry.
- mem_wmask  output  4  mask of the head entry.
- mem_dmem_we  output  1  head entry targets dmem; qualified by mem_wvalid.
- mem_imem_we  output  1  head entry targets imem; qualified by mem_wvalid.
- ld_addr  input  32  byte address of the load currently in the MEM stage.
- ld_hit  output  1  a pending dmem entry matches ld_addr[31:2].
- empty  output  1  no pending entries; used by fence/halt logic.

Behaviour:
- State:
  - Entry array of {waddr, data, mask, dmem, imem}.
  - wptr and rptr, each log2(DEPTH) bits, wrapping modulo DEPTH.
  - count, 0..DEPTH.
- Reset (asynchronous):
  - wptr, rptr and count go to 0; all entries are discarded, including any not yet drained.
  - Outputs after reset: mem_wvalid=0, mem_waddr=0, mem_wdata=0, mem_wmask=0, mem_dmem_we=0, mem_imem_we=0, ld_hit=0, empty=1, st_ready=1.
- Push:
  - A store is pushed when st_valid & st_ready & (st_mask != 0) & (st_dmem_we | st_imem_we).
  - The entry is written at wptr, then wptr increments.
  - A handshake with a zero mask or no target completes with st_ready high, but no entry is created (silent drop).
- st_ready = (count != DEPTH). It is evaluated on the current count and does not include a same-cycle pop; there is no full pass-through.
- Head presentation:
  - mem_wvalid = (count != 0).
  - mem_* outputs show the entry at rptr.
  - When empty, all mem_* outputs are 0.
- Pop: occurs when mem_wvalid & mem_wready; rptr increments.
- Latency:
  - A store pushed in cycle N appears on the mem port in cycle N+1 at the earliest; there is no combinational bypass.
  - Entries drain strictly in push order.
- Simultaneous push and pop: count is unchanged. This is legal at any count below DEPTH; at count=DEPTH only the pop occurs.
- ld_hit:
  - Combinational OR over the valid entries that have dmem=1 and waddr == ld_addr[31:2].
  - The store being pushed in the same cycle is not compared.
  - An entry popping in the current cycle is still compared.
  - imem-only entries never cause a hit.
- empty = (count == 0).
- Wrap-around: the pointers wrap silently. Full versus empty is distinguished only by count, never by pointer equality.

Optional Feature:
- Macro: STORE_BUF_COALESCE_EN.
- When defined, an incoming valid store merges into the youngest entry (index wptr-1) instead of allocating a new one, if all of the following hold:
  - count != 0;
  - the word address is equal;
  - the dmem and imem flags are equal;
  - the youngest entry is not the head being popped this cycle.
- Merge rules:
  - Each byte lane whose st_mask bit is set takes the new data.
  - The stored mask becomes the OR of the old and new masks.
  - wptr and count are unchanged.
- In this mode st_ready = (count != DEPTH) | coalesce_possible, so a merge is accepted even when the buffer is full.
- When the macro is not defined, every store allocates its own entry, and behaviour is exactly as described in Behaviour.

Test Plan:
- Reset, then st_valid with addr 0x1000_0004, data 0x0000_AB00, mask 4'b0010, dmem=1, mem_wready=1 -> cycle after the push: mem_wvalid=1, mem_waddr=0x0400_0001, mem_wmask=4'b0010; empty=1 one cycle later.
- mem_wready=0, push 5 stores with DEPTH=4 -> st_ready drops after 4 pushes and the 5th is held off; raise mem_wready -> the 4 entries drain in order, then the 5th is accepted.
- Entry pending at dmem word 0x0400_0010, ld_addr=0x1000_0040 -> ld_hit=1; ld_addr=0x1000_0044 -> ld_hit=0; an imem-only entry at the same address -> ld_hit=0.
- Buffer full with mem_wready=1 and st_valid=1 -> in that cycle only a pop occurs and count becomes 3; the following cycle the push and a pop happen together and count stays 3.
- Assert rst mid-drain with 3 entries pending -> mem_wvalid=0 immediately, empty=1, and no further writes appear after rst is released.
- With STORE_BUF_COALESCE_EN and mem_wready=0: an SB to 0x1000_0000 (mask 0001, data 0x11) followed by an SB to 0x1000_0001 (mask 0010, data 0x2200) -> a single entry with mask 0011 and data 0x0000_2211; without the macro -> two entries.
